// File: rtl/deepfifo_burst_sched.sv
// rtl/deepfifo_burst_sched.sv - arbitrates the shared DDR port between ring write and read bursts
// Optional burst statistics counters are built when DEEPFIFO_SCHED_STATS_EN is defined.

module deepfifo_burst_sched #(
  parameter int RAM_ADDR_W      = 30,
  parameter int WORD_BYTES_LOG2 = 6,
  parameter int BURST_LOG2      = 6,
  parameter int PRE_URGENT      = 192,
  parameter int POST_DEPTH      = 256,
  localparam int RB_W = RAM_ADDR_W - WORD_BYTES_LOG2 - BURST_LOG2
) (
  input  logic          i_axi_clk,
  input  logic          i_axi_aresetn,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [7:0]    i_pre_rd_count,
  input  logic [7:0]    i_post_wr_count,
  input  logic          i_post_full,
  output logic          o_wr_cmd_valid,
  input  logic          i_wr_cmd_ready,
  output logic [31:0]   o_wr_cmd_addr,
  input  logic          i_wr_done,
  output logic          o_rd_cmd_valid,
  input  logic          i_rd_cmd_ready,
  output logic [31:0]   o_rd_cmd_addr,
  input  logic          i_rd_done,
  output logic [7:0]    o_cmd_len,
  output logic [RB_W:0] o_ddr_level,
  output logic          o_ddr_full,
  output logic          o_ddr_empty,
  output logic          o_ring_full_seen,
  output logic          o_busy,
  output logic [31:0]   o_stat_wr_bursts,
  output logic [31:0]   o_stat_rd_bursts
);

  localparam int              OFF_W       = WORD_BYTES_LOG2 + BURST_LOG2;
  localparam int              BURST_LEN   = 1 << BURST_LOG2;
  localparam logic [7:0]      LP_BURST    = 8'(BURST_LEN);
  localparam logic [7:0]      LP_URGENT   = 8'(PRE_URGENT);
  localparam logic [7:0]      LP_POST_THR = 8'(POST_DEPTH - BURST_LEN);
  localparam logic [RB_W:0]   LP_RING     = {1'b1, {RB_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [RB_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [RB_W:0]   r_res_level, r_com_level;
  logic            r_last_rd, r_flush_pend, r_ring_full_seen;
  logic            w_we, w_re, w_urgent, w_flush_now;
  logic            w_clear, w_wr_hs, w_rd_hs, w_wr_commit;

  always_comb begin
    w_we        = i_enable && (i_pre_rd_count >= LP_BURST) && (r_res_level < LP_RING);
    w_re        = i_enable && (r_com_level != '0) && !i_post_full && (i_post_wr_count <= LP_POST_THR);
    w_urgent    = i_pre_rd_count >= LP_URGENT;
    w_flush_now = i_flush || r_flush_pend;
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_wr_hs     = 1'b0;
    w_rd_hs     = 1'b0;
    w_wr_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending or fresh flush owns the IDLE cycle; no grant alongside it.
        if (w_flush_now) w_clear = 1'b1;
        else if (w_we && (w_urgent || !w_re || r_last_rd)) w_state_nxt = S_WR_REQ;
        else if (w_re) w_state_nxt = S_RD_REQ;
      end
      S_WR_REQ: if (i_wr_cmd_ready) begin
        w_wr_hs     = 1'b1;
        w_state_nxt = S_WR_WAIT;
      end
      S_WR_WAIT: if (i_wr_done) begin
        w_state_nxt = S_IDLE;
        w_clear     = w_flush_now;
        w_wr_commit = !w_flush_now;
      end
      S_RD_REQ: if (i_rd_cmd_ready) begin
        w_rd_hs     = 1'b1;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: if (i_rd_done) begin
        w_state_nxt = S_IDLE;
        w_clear     = w_flush_now;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_res_level      <= '0;
      r_com_level      <= '0;
      r_last_rd        <= 1'b1;
      r_flush_pend     <= 1'b0;
      r_ring_full_seen <= 1'b0;
    end else if (w_clear) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_res_level      <= '0;
      r_com_level      <= '0;
      r_last_rd        <= 1'b1;
      r_flush_pend     <= 1'b0;
      r_ring_full_seen <= 1'b0;
    end else begin
      if (i_flush) r_flush_pend <= 1'b1;
      if (w_wr_hs) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_res_level <= r_res_level + 1'b1;
        r_last_rd   <= 1'b0;
      end
      if (w_rd_hs) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_res_level <= r_res_level - 1'b1;
        r_com_level <= r_com_level - 1'b1;
        r_last_rd   <= 1'b1;
      end
      if (w_wr_commit) r_com_level <= r_com_level + 1'b1;
      if (r_state == S_IDLE && i_pre_rd_count >= LP_BURST && r_res_level == LP_RING)
        r_ring_full_seen <= 1'b1;
    end
  end

  assign o_wr_cmd_valid   = (r_state == S_WR_REQ);
  assign o_rd_cmd_valid   = (r_state == S_RD_REQ);
  assign o_wr_cmd_addr    = 32'({r_wr_ptr, {OFF_W{1'b0}}});
  assign o_rd_cmd_addr    = 32'({r_rd_ptr, {OFF_W{1'b0}}});
  assign o_cmd_len        = 8'(BURST_LEN - 1);
  assign o_ddr_level      = r_com_level;
  assign o_ddr_full       = (r_res_level == LP_RING);
  assign o_ddr_empty      = (r_com_level == '0);
  assign o_ring_full_seen = r_ring_full_seen;
  assign o_busy           = (r_state != S_IDLE);

`ifdef DEEPFIFO_SCHED_STATS_EN
  logic [31:0] r_stat_wr, r_stat_rd;

  always_ff @(posedge i_axi_clk or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else if (w_clear) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_wr_hs) r_stat_wr <= r_stat_wr + 32'd1;
      if (w_rd_hs) r_stat_rd <= r_stat_rd + 32'd1;
    end
  end

  assign o_stat_wr_bursts = r_stat_wr;
  assign o_stat_rd_bursts = r_stat_rd;
`else
  assign o_stat_wr_bursts = '0;
  assign o_stat_rd_bursts = '0;
`endif

endmodule

// File: tb/tb_deepfifo_burst_sched.sv
// tb/tb_deepfifo_burst_sched.sv - randomized directed bench for deepfifo_burst_sched (4-burst ring)
// Expected stats follow DEEPFIFO_SCHED_STATS_EN when the bench is built with it.

module tb_deepfifo_burst_sched;

  localparam int RING = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, flush, post_full, wr_ready, wr_done, rd_ready, rd_done;
  logic [7:0]  pre_cnt, post_wr;
  logic        wr_v, rd_v, full, empty, rfs, busy;
  logic [31:0] wr_addr, rd_addr, st_wr, st_rd;
  logic [7:0]  cmd_len;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_wr_ptr, m_res, m_com;
  bit          m_last_w, m_rfs;
  logic [31:0] m_ring[$];
  int unsigned m_st_wr, m_st_rd;

  deepfifo_burst_sched #(.RAM_ADDR_W(14)) dut (
    .i_axi_clk(clk), .i_axi_aresetn(rst_n), .i_enable(enable), .i_flush(flush),
    .i_pre_rd_count(pre_cnt), .i_post_wr_count(post_wr), .i_post_full(post_full),
    .o_wr_cmd_valid(wr_v), .i_wr_cmd_ready(wr_ready), .o_wr_cmd_addr(wr_addr), .i_wr_done(wr_done),
    .o_rd_cmd_valid(rd_v), .i_rd_cmd_ready(rd_ready), .o_rd_cmd_addr(rd_addr), .i_rd_done(rd_done),
    .o_cmd_len(cmd_len), .o_ddr_level(level), .o_ddr_full(full), .o_ddr_empty(empty),
    .o_ring_full_seen(rfs), .o_busy(busy), .o_stat_wr_bursts(st_wr), .o_stat_rd_bursts(st_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wr_ptr = 0; m_res = 0; m_com = 0; m_last_w = 1'b0; m_rfs = 1'b0;
    m_ring.delete(); m_st_wr = 0; m_st_rd = 0;
  endtask

  // 0 = no grant, 1 = write, 2 = read
  function automatic int predict();
    bit we, re;
    we = enable && pre_cnt >= 64 && m_res < RING;
    re = enable && m_com != 0 && !post_full && post_wr <= 192;
    if (we && pre_cnt >= 192) return 1;
    if (we && re) return m_last_w ? 2 : 1;
    if (we) return 1;
    if (re) return 2;
    return 0;
  endfunction

  task automatic idle_eval();
    if (pre_cnt >= 64 && m_res == RING) m_rfs = 1'b1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(m_com));
    chk({tag, "_empty"}, 32'(empty), 32'(m_com == 0));
    chk({tag, "_full"}, 32'(full), 32'(m_res == RING));
    chk({tag, "_rfs"}, 32'(rfs), 32'(m_rfs));
`ifdef DEEPFIFO_SCHED_STATS_EN
    chk({tag, "_stwr"}, st_wr, m_st_wr);
    chk({tag, "_strd"}, st_rd, m_st_rd);
`else
    chk({tag, "_stwr"}, st_wr, 32'd0);
    chk({tag, "_strd"}, st_rd, 32'd0);
`endif
  endtask

  // fl_mode: 0 none, 1 flush pulse while waiting for done, 2 flush in the done cycle
  task automatic do_burst(input int g, input int fl_mode);
    int k;
    logic [31:0] exp_addr;
    idle_eval();
    exp_addr = (g == 1) ? 32'(m_wr_ptr * 4096) : ((m_ring.size() > 0) ? m_ring[0] : 32'hdead);
    k = 0;
    while (!(wr_v || rd_v) && k < 20) begin step(); k++; end
    chk("grant_latency", k, 1);
    chk("grant_side", {30'd0, wr_v, rd_v}, (g == 1) ? 32'd2 : 32'd1);
    chk("cmd_addr", (g == 1) ? wr_addr : rd_addr, exp_addr);
    repeat ($urandom_range(0, 2)) begin
      step();
      chk("valid_hold", 32'(g == 1 ? wr_v : rd_v), 32'd1);
      chk("addr_hold", (g == 1) ? wr_addr : rd_addr, exp_addr);
    end
    if (g == 1) wr_ready = 1'b1; else rd_ready = 1'b1;
    step();
    wr_ready = 1'b0; rd_ready = 1'b0;
    chk("valid_drop", {30'd0, wr_v, rd_v}, 32'd0);
    if (g == 1) begin
      m_wr_ptr = (m_wr_ptr + 1) % RING; m_res++; m_last_w = 1'b1; m_st_wr++;
    end else begin
      void'(m_ring.pop_front()); m_res--; m_com--; m_last_w = 1'b0; m_st_rd++;
    end
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) begin
        if (g == 1) rd_done = 1'b1; else wr_done = 1'b1;
      end
      step();
      wr_done = 1'b0; rd_done = 1'b0;
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_level", 32'(level), 32'(m_com));
    end
    if (fl_mode == 1) begin
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_pend_busy", 32'(busy), 32'd1);
      chk("flush_pend_level", 32'(level), 32'(m_com));
    end
    flush = (fl_mode == 2);
    if (g == 1) wr_done = 1'b1; else rd_done = 1'b1;
    step();
    wr_done = 1'b0; rd_done = 1'b0; flush = 1'b0;
    if (fl_mode != 0) model_clear();
    else if (g == 1) begin m_com++; m_ring.push_back(exp_addr); end
    chk("done_busy", 32'(busy), 32'd0);
    check_status("done");
  endtask

  task automatic iter();
    int g;
    g = predict();
    if (g == 0) begin
      idle_eval();
      step();
      chk("no_grant", {30'd0, wr_v, rd_v}, 32'd0);
      check_status("idle");
    end else begin
      do_burst(g, 0);
    end
  endtask

  task automatic flush_idle();
    enable = 1'b0; pre_cnt = 8'd0; flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
    chk("flush_busy", 32'(busy), 32'd0);
    check_status("flush");
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; post_full = 1'b0;
    wr_ready = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; rd_done = 1'b0;
    pre_cnt = 8'd0; post_wr = 8'd0;
    model_clear();
    step(); step();
    chk("rst_wr_v", 32'(wr_v), 32'd0);
    chk("rst_rd_v", 32'(rd_v), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_cmd_len", 32'(cmd_len), 32'd63);
    chk("rst_busy", 32'(busy), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    step();

    // Alternating writes and reads with the ring mostly empty.
    enable = 1'b1; pre_cnt = 8'd64;
    repeat (6) iter();

    // Urgent pre-FIFO level forces back-to-back writes, then alternation resumes.
    flush_idle();
    enable = 1'b1; post_full = 1'b1; pre_cnt = 8'd64;
    repeat (2) iter();
    post_full = 1'b0; pre_cnt = 8'd200;
    repeat (3) iter();
    pre_cnt = 8'd100;
    repeat (4) iter();

    // Fill the ring with reads blocked.
    flush_idle();
    enable = 1'b1; post_full = 1'b1; pre_cnt = 8'd64;
    repeat (6) iter();
    chk("ring_full", 32'(full), 32'd1);
    chk("ring_full_seen", 32'(rfs), 32'd1);

    // enable low blocks new grants.
    enable = 1'b0; post_full = 1'b0;
    repeat (2) iter();

    // Pointer wrap over five write/read pairs.
    flush_idle();
    enable = 1'b1; post_full = 1'b0; pre_cnt = 8'd64;
    repeat (10) iter();
    chk("wrap_level", 32'(level), 32'd0);

    // Flush during the write wait, and flush together with done.
    post_full = 1'b1;
    iter();
    do_burst(predict(), 1);
    do_burst(predict(), 2);
    iter();

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 14) == 0) flush_idle();
      enable    = ($urandom_range(0, 7) != 0);
      pre_cnt   = 8'($urandom_range(0, 255));
      post_wr   = 8'($urandom_range(0, 255));
      post_full = ($urandom_range(0, 3) == 0);
      iter();
    end

    // Asynchronous reset while a read command is pending.
    flush_idle();
    enable = 1'b1; post_full = 1'b1; post_wr = 8'd0; pre_cnt = 8'd64;
    iter();
    pre_cnt = 8'd0; post_full = 1'b0;
    step();
    chk("pre_rst_rd_v", 32'(rd_v), 32'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_rd_v", 32'(rd_v), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    check_status("arst");
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {30'd0, wr_v, rd_v}, 32'd0);
    check_status("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
